// File: rtl/mem_port_pkg.sv
// Shared types and constants for the memory port request front-end.
// Optional feature macro used by the top: MEM_PORT_RAW_STALL_EN.
package mem_port_pkg;

    // Default memory geometry and pipeline depths
    localparam int DATA_W_DEFAULT = 8;
    localparam int ADDR_W_DEFAULT = 3;
    localparam int RD_LAT_DEFAULT = 6;
    localparam int WR_LAT_DEFAULT = 6;

    // Request bundle for the default geometry
    typedef struct packed {
        logic                      we;
        logic [ADDR_W_DEFAULT-1:0] addr;
        logic [DATA_W_DEFAULT-1:0] wdata;
    } req_t;

    // Width of a counter that must hold values 0..depth inclusive
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// First-word-fall-through response FIFO for read data returning from the memory.
// Head data is forced to zero while empty so the consumer never sees stale words.
// A push and a pop on the same edge are both honoured, even when full.
module mem_rsp_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W:0]        r_count;
    logic                  w_push_en;
    logic                  w_pop_en;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count   = r_count;
    assign w_pop_en  = i_pop & ~o_empty;
    // When full, the slot being written is the one being popped this edge
    assign w_push_en = i_push & (~o_full | w_pop_en);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

    // Storage array: data only, never reset
    always_ff @(posedge i_clk) begin
        if (w_push_en) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_en) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop_en) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_req_ctrl.sv
// Request front-end for one port of the latency-configurable dual-port memory.
// Drives the memory port combinationally from accepted requests, tracks reads
// in a valid pipeline matched to the memory read latency, and captures returning
// data into a response FIFO. Reads are credit-limited so the FIFO never overflows.
// Optional macro MEM_PORT_RAW_STALL_EN: hold reads that hit an in-flight write.
module mem_port_req_ctrl
    import mem_port_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W_DEFAULT,
    parameter int ADDR_WIDTH     = ADDR_W_DEFAULT,
    parameter int MEM_RD_LATENCY = RD_LAT_DEFAULT,
    parameter int MEM_WR_LATENCY = WR_LAT_DEFAULT,
    parameter int RSP_DEPTH      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    input  logic [DATA_WIDTH-1:0] i_mem_dout,
    output logic                  o_busy
);

    localparam int CNT_W = credit_w(RSP_DEPTH);

    logic                      r_active;
    logic [MEM_RD_LATENCY-1:0] r_rd_vld_sr;
    logic [MEM_WR_LATENCY-1:0] r_wr_vld_sr;
    logic [CNT_W-1:0]          r_rd_outstanding;

    logic                      w_accept;
    logic                      w_rd_accept;
    logic                      w_wr_accept;
    logic                      w_capture;
    logic                      w_credit_ok;
    logic                      w_hazard_stall;
    logic [CNT_W:0]            w_credit_used;
    logic [CNT_W-1:0]          w_fifo_count;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_rsp_pop;

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    // Credit covers both reads still in the memory pipeline and words already
    // parked in the FIFO, so every accepted read is guaranteed a slot.
    assign w_credit_used = {1'b0, r_rd_outstanding} + {1'b0, w_fifo_count};
    assign w_credit_ok   = ~w_fifo_full & (w_credit_used < (CNT_W+1)'(RSP_DEPTH));

    // r_active keeps ready low while reset is held and until the first edge after release
    assign o_req_ready = r_active & ~w_hazard_stall & (i_req_we | w_credit_ok);
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_rd_accept = w_accept & ~i_req_we;
    assign w_wr_accept = w_accept & i_req_we;

    // The memory registers these itself, so they pass straight through
    assign o_mem_en   = w_accept;
    assign o_mem_we   = w_wr_accept;
    assign o_mem_addr = i_req_addr;
    assign o_mem_din  = i_req_wdata;

    // Ready gate: low in reset, high from the first edge after release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read tracking
    // ------------------------------------------------------------------
    // The last stage marks the edge on which i_mem_dout carries that read's word
    assign w_capture = r_rd_vld_sr[MEM_RD_LATENCY-1];

    // Read valid pipeline, one bit per memory read-latency edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_vld_sr <= '0;
        end else begin
            for (int k = MEM_RD_LATENCY - 1; k > 0; k--) begin
                r_rd_vld_sr[k] <= r_rd_vld_sr[k-1];
            end
            r_rd_vld_sr[0] <= w_rd_accept;
        end
    end

    // Outstanding-read counter: +1 on read accept, -1 on capture, unchanged on both
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_outstanding <= '0;
        end else begin
            case ({w_rd_accept, w_capture})
                2'b10:   r_rd_outstanding <= r_rd_outstanding + CNT_W'(1);
                2'b01:   r_rd_outstanding <= r_rd_outstanding - CNT_W'(1);
                default: r_rd_outstanding <= r_rd_outstanding;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write tracking
    // ------------------------------------------------------------------
    // Write valid pipeline: a write is in flight until the memory array holds it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_vld_sr <= '0;
        end else begin
            for (int k = MEM_WR_LATENCY - 1; k > 0; k--) begin
                r_wr_vld_sr[k] <= r_wr_vld_sr[k-1];
            end
            r_wr_vld_sr[0] <= w_wr_accept;
        end
    end

`ifdef MEM_PORT_RAW_STALL_EN
    logic [ADDR_WIDTH-1:0] r_wr_addr_sr [MEM_WR_LATENCY];
    logic                  w_addr_hit;

    // Address of each in-flight write, aligned with r_wr_vld_sr
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < MEM_WR_LATENCY; k++) begin
                r_wr_addr_sr[k] <= '0;
            end
        end else begin
            for (int k = MEM_WR_LATENCY - 1; k > 0; k--) begin
                r_wr_addr_sr[k] <= r_wr_addr_sr[k-1];
            end
            r_wr_addr_sr[0] <= i_req_addr;
        end
    end

    // Does the presented address match any write the memory has not yet landed?
    always_comb begin
        w_addr_hit = 1'b0;
        for (int k = 0; k < MEM_WR_LATENCY; k++) begin
            if (r_wr_vld_sr[k] && (r_wr_addr_sr[k] == i_req_addr)) begin
                w_addr_hit = 1'b1;
            end
        end
    end

    // Only reads wait; writes to the same address keep their order in the memory
    assign w_hazard_stall = ~i_req_we & w_addr_hit;
`else
    // Reads issue immediately and may observe the pre-write value
    assign w_hazard_stall = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    assign w_rsp_pop = o_rsp_valid & i_rsp_ready;

    mem_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_capture),
        .i_wdata (i_mem_dout),
        .i_pop   (w_rsp_pop),
        .o_rdata (o_rsp_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_rsp_valid = ~w_fifo_empty;
    assign o_busy      = (|r_rd_vld_sr) | (|r_wr_vld_sr) | ~w_fifo_empty;

endmodule
